// File: rtl/cruise_control_fsm.sv
// Cruise control FSM with a simple vehicle speed model; outputs are registered, 1-cycle latency, no backpressure.
// Define CRUISE_RESUME_EN to build in STANDBY/resume; otherwise brake/cancel drops to IDLE and clears the set-point.
module cruise_control_fsm #(
    parameter logic [7:0] MIN_CRUISE = 8'd45,
    parameter logic [7:0] MAX_SPEED  = 8'd200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       throttle,
    input  logic       brake,
    input  logic       set,
    input  logic       accel,
    input  logic       coast,
    input  logic       cancel,
    input  logic       resume,
    output logic [7:0] speed,
    output logic [7:0] cruise_speed,
    output logic       cruise_on
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRUISE = 3'd1,
        S_ACCEL  = 3'd2,
        S_COAST  = 3'd3
`ifdef CRUISE_RESUME_EN
        ,
        S_STANDBY = 3'd4
`endif
    } state_t;

    // Where brake/cancel lands when cruise is engaged.
`ifdef CRUISE_RESUME_EN
    localparam state_t S_DROP = S_STANDBY;
`else
    localparam state_t S_DROP = S_IDLE;
`endif

    state_t     state_q, state_d;
    logic [7:0] speed_q, speed_d;
    logic [7:0] cs_q, cs_d;
    logic       cruise_on_q;
    logic       stop;
    logic       can_set;

`ifndef CRUISE_RESUME_EN
    logic unused_resume;
    assign unused_resume = resume;
`endif

    function automatic logic [7:0] up1(input logic [7:0] v);
        return (v >= MAX_SPEED) ? MAX_SPEED : v + 8'd1;
    endfunction

    function automatic logic [7:0] dn1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    function automatic logic [7:0] dn2(input logic [7:0] v);
        return (v < 8'd2) ? 8'd0 : v - 8'd2;
    endfunction

    function automatic logic engaged(input state_t s);
        return (s == S_CRUISE) || (s == S_ACCEL) || (s == S_COAST);
    endfunction

    assign stop    = brake | cancel;
    assign can_set = set && (speed_q >= MIN_CRUISE);

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cs_d    = cs_q;
        case (state_q)
            S_IDLE: begin
                speed_d = throttle ? up1(speed_q) : dn1(speed_q);
                if (!stop && can_set) begin
                    state_d = S_CRUISE;
                    cs_d    = speed_q;
                end
            end
            S_CRUISE: begin
                if (throttle || (speed_q < cs_q)) begin
                    speed_d = up1(speed_q);
                end else if (speed_q > cs_q) begin
                    speed_d = dn1(speed_q);
                end
                if (stop) begin
                    state_d = S_DROP;
`ifndef CRUISE_RESUME_EN
                    cs_d    = 8'd0;
`endif
                end else if (set) begin
                    // A set below the floor is swallowed rather than passed to accel/coast.
                    if (can_set) begin
                        cs_d = speed_q;
                    end
                end else if (accel) begin
                    state_d = S_ACCEL;
                end else if (coast) begin
                    state_d = S_COAST;
                end
            end
            S_ACCEL: begin
                speed_d = up1(speed_q);
                if (stop) begin
                    state_d = S_DROP;
`ifndef CRUISE_RESUME_EN
                    cs_d    = 8'd0;
`endif
                end else begin
                    cs_d    = up1(cs_q);
                    state_d = accel ? S_ACCEL : S_CRUISE;
                end
            end
            S_COAST: begin
                speed_d = dn1(speed_q);
                if (stop) begin
                    state_d = S_DROP;
`ifndef CRUISE_RESUME_EN
                    cs_d    = 8'd0;
`endif
                end else begin
                    cs_d = (cs_q > MIN_CRUISE) ? cs_q - 8'd1 : cs_q;
                    if (accel) begin
                        state_d = S_ACCEL;
                    end else if (coast) begin
                        state_d = S_COAST;
                    end else begin
                        state_d = S_CRUISE;
                    end
                end
            end
`ifdef CRUISE_RESUME_EN
            S_STANDBY: begin
                speed_d = throttle ? up1(speed_q) : dn1(speed_q);
                if (!stop) begin
                    if (can_set) begin
                        state_d = S_CRUISE;
                        cs_d    = speed_q;
                    end else if (resume) begin
                        state_d = S_CRUISE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                speed_d = 8'd0;
                cs_d    = 8'd0;
            end
        endcase
        // Braking overrides every other speed contribution.
        if (brake) begin
            speed_d = dn2(speed_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            speed_q     <= 8'd0;
            cs_q        <= 8'd0;
            cruise_on_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            cs_q        <= cs_d;
            cruise_on_q <= engaged(state_d);
        end
    end

    assign speed        = speed_q;
    assign cruise_speed = cs_q;
    assign cruise_on    = cruise_on_q;

endmodule

// File: tb/tb_cruise_control_fsm.sv
// Bench for cruise_control_fsm: vector table, directed corner sequences and random traffic vs. a behavioural model.
module tb_cruise_control_fsm;

    localparam int MIN = 45;
    localparam int MAX = 200;
`ifdef CRUISE_RESUME_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    typedef struct packed {
        logic thr;
        logic brk;
        logic st;
        logic acc;
        logic cst;
        logic cnl;
        logic rsm;
    } in_t;

    typedef struct {
        in_t in;
        int  speed;
        int  cs;
        bit  on;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    in_t        drv = '0;
    logic [7:0] speed;
    logic [7:0] cruise_speed;
    logic       cruise_on;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: engaged flag, ramp direction and a standby memory flag.
    int m_speed, m_cs, m_ramp;
    bit m_on, m_standby;

    cruise_control_fsm dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .throttle     (drv.thr),
        .brake        (drv.brk),
        .set          (drv.st),
        .accel        (drv.acc),
        .coast        (drv.cst),
        .cancel       (drv.cnl),
        .resume       (drv.rsm),
        .speed        (speed),
        .cruise_speed (cruise_speed),
        .cruise_on    (cruise_on)
    );

    always #5 clock = ~clock;

    function automatic in_t mk(input bit thr, input bit brk, input bit st, input bit acc,
                               input bit cst, input bit cnl, input bit rsm);
        in_t r;
        r.thr = thr; r.brk = brk; r.st = st; r.acc = acc;
        r.cst = cst; r.cnl = cnl; r.rsm = rsm;
        return r;
    endfunction

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAX) return MAX;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input in_t i);
        int  dv, old;
        bit  stop;
        if (!rst) begin
            m_speed = 0; m_cs = 0; m_ramp = 0; m_on = 0; m_standby = 0;
            return;
        end
        stop = i.brk | i.cnl;
        old  = m_speed;
        if (i.brk)                    dv = -2;
        else if (m_on && m_ramp != 0) dv = m_ramp;
        else if (i.thr)               dv = 1;
        else if (m_on)                dv = (m_cs > old) ? 1 : ((m_cs < old) ? -1 : 0);
        else                          dv = -1;
        m_speed = clamp(old + dv);
        if (m_on) begin
            if (stop) begin
                m_on = 0; m_ramp = 0; m_standby = RES_EN;
                if (!RES_EN) m_cs = 0;
            end else if (m_ramp == 1) begin
                m_cs   = clamp(m_cs + 1);
                m_ramp = i.acc ? 1 : 0;
            end else if (m_ramp == -1) begin
                if (m_cs > MIN) m_cs = m_cs - 1;
                m_ramp = i.acc ? 1 : (i.cst ? -1 : 0);
            end else if (i.st) begin
                if (old >= MIN) m_cs = old;
            end else if (i.acc) begin
                m_ramp = 1;
            end else if (i.cst) begin
                m_ramp = -1;
            end
        end else if (!stop) begin
            if (i.st && old >= MIN) begin
                m_on = 1; m_cs = old; m_standby = 0;
            end else if (m_standby && i.rsm) begin
                m_on = 1; m_standby = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input in_t i);
        @(negedge clock);
        reset_n = rst;
        drv     = i;
        @(posedge clock);
        model_edge(rst, i);
        #1;
        check("model speed", int'(speed), m_speed);
        check("model cruise_speed", int'(cruise_speed), m_cs);
        check("model cruise_on", int'(cruise_on), int'(m_on));
    endtask

    task automatic run(input int n, input in_t i);
        for (int k = 0; k < n; k++) step(1'b1, i);
    endtask

    task automatic do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        check("reset speed", int'(speed), 0);
        check("reset cruise_speed", int'(cruise_speed), 0);
        check("reset cruise_on", int'(cruise_on), 0);
    endtask

    // Brings the car to a steady cruise at 'v' (v+1 the cycle after set, then pulled back).
    task automatic cruise_at(input int v);
        do_reset();
        run(v, mk(1,0,0,0,0,0,0));
        step(1'b1, mk(1,0,1,0,0,0,0));
        step(1'b1, '0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{mk(0,1,0,0,0,0,0), 0, 0, 1'b0};
        tbl[1] = '{mk(1,0,0,0,0,0,0), 1, 0, 1'b0};
        tbl[2] = '{mk(1,0,0,0,0,0,0), 2, 0, 1'b0};
        tbl[3] = '{mk(0,1,0,0,0,0,0), 0, 0, 1'b0};
        tbl[4] = '{mk(1,0,0,0,0,0,0), 1, 0, 1'b0};
        tbl[5] = '{mk(0,0,1,0,0,0,0), 0, 0, 1'b0};
        tbl[6] = '{mk(1,0,1,0,0,0,0), 1, 0, 1'b0};
        tbl[7] = '{mk(1,1,0,0,0,0,0), 0, 0, 1'b0};

        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, tbl[k].in);
            check($sformatf("vec%0d speed", k), int'(speed), tbl[k].speed);
            check($sformatf("vec%0d cruise_speed", k), int'(cruise_speed), tbl[k].cs);
            check($sformatf("vec%0d cruise_on", k), int'(cruise_on), int'(tbl[k].on));
        end

        // Engage at 50 after 50 cycles of throttle.
        do_reset();
        run(50, mk(1,0,0,0,0,0,0));
        check("ramp50 speed", int'(speed), 50);
        step(1'b1, mk(0,0,1,0,0,0,0));
        check("set50 cruise_speed", int'(cruise_speed), 50);
        check("set50 cruise_on", int'(cruise_on), 1);
        check("set50 speed", int'(speed), 49);
        step(1'b1, '0);
        check("hold50 speed", int'(speed), 50);

        // Speed 30 is below the engage floor.
        do_reset();
        run(30, mk(1,0,0,0,0,0,0));
        step(1'b1, mk(1,0,1,0,0,0,0));
        check("low set cruise_on", int'(cruise_on), 0);
        check("low set cruise_speed", int'(cruise_speed), 0);

        // Accel 5 then coast down to the floor.
        cruise_at(60);
        check("cruise60 speed", int'(speed), 60);
        run(5, mk(0,0,0,1,0,0,0));
        step(1'b1, '0);
        check("accel cruise_speed", int'(cruise_speed), 65);
        check("accel speed", int'(speed), 65);
        check("accel cruise_on", int'(cruise_on), 1);
        run(30, mk(0,0,0,0,1,0,0));
        check("coast floor cruise_speed", int'(cruise_speed), 45);
        check("coast speed", int'(speed), 36);

        // Brake, then resume.
        cruise_at(60);
        run(3, mk(0,1,0,0,0,0,0));
        check("brake speed", int'(speed), 54);
        check("brake cruise_on", int'(cruise_on), 0);
        check("brake cruise_speed", int'(cruise_speed), RES_EN ? 60 : 0);
        step(1'b1, mk(0,0,0,0,0,0,1));
        check("resume cruise_on", int'(cruise_on), RES_EN ? 1 : 0);
        check("resume speed", int'(speed), 53);
        run(9, '0);
        check("after resume speed", int'(speed), RES_EN ? 60 : 44);
        check("after resume cruise_speed", int'(cruise_speed), RES_EN ? 60 : 0);

        // Reset mid-ACCEL.
        cruise_at(100);
        run(3, mk(0,0,0,1,0,0,0));
        step(1'b0, mk(0,0,0,1,0,0,0));
        check("rst accel speed", int'(speed), 0);
        check("rst accel cruise_speed", int'(cruise_speed), 0);
        check("rst accel cruise_on", int'(cruise_on), 0);
        step(1'b1, mk(0,0,0,1,0,0,0));
        check("post rst cruise_on", int'(cruise_on), 0);

        // Saturation at MAX_SPEED for speed and set-point.
        do_reset();
        run(205, mk(1,0,0,0,0,0,0));
        check("sat speed", int'(speed), 200);
        step(1'b1, mk(1,0,1,0,0,0,0));
        run(3, mk(0,0,0,1,0,0,0));
        step(1'b1, '0);
        check("sat cruise_speed", int'(cruise_speed), 200);
        check("sat speed cruise", int'(speed), 200);

        // Random traffic with drifting throttle bias.
        do_reset();
        begin
            int thr_pct;
            thr_pct = 50;
            for (int c = 0; c < 3000; c++) begin
                in_t r;
                bit  rst;
                if (c % 100 == 0) thr_pct = $urandom_range(95, 10);
                r.thr = ($urandom_range(99) < thr_pct);
                r.brk = ($urandom_range(15) == 0);
                r.cnl = ($urandom_range(31) == 0);
                r.st  = ($urandom_range(7) == 0);
                r.acc = ($urandom_range(5) == 0);
                r.cst = ($urandom_range(5) == 0);
                r.rsm = ($urandom_range(9) == 0);
                rst   = ($urandom_range(499) != 0);
                step(rst, r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cruise_control_fsm.md
CRUISE_CONTROL_FSM -- requirements
Module: cruise_control_fsm

Interface
REQ-001 The block SHALL have parameter MIN_CRUISE, default 8'd45: the lowest speed at which cruise may engage and the floor for the held speed.
REQ-002 The block SHALL have parameter MAX_SPEED, default 8'd200: the saturation ceiling for speed and cruise_speed.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have the following 1-bit inputs, all level-sampled each clock:
- throttle: driver accelerating.
- brake: driver braking.
- set: engage cruise at current speed.
- accel: raise held speed while cruising.
- coast: lower held speed while cruising.
- cancel: disengage cruise.
- resume: re-engage at the held speed.
REQ-006 The block SHALL have the following registered outputs:
- speed, output, 8 bits: vehicle speed model.
- cruise_speed, output, 8 bits: held cruise set-point.
- cruise_on, output, 1 bit: high in CRUISE, ACCEL and COAST.

Function
REQ-007 The FSM SHALL have five states: IDLE, CRUISE, ACCEL, COAST and STANDBY.
REQ-008 Input priority within a cycle SHALL be, highest first: brake, cancel, set, accel, coast, resume.
REQ-009 IDLE transitions:
- set with speed>=MIN_CRUISE SHALL go to CRUISE and load cruise_speed<=speed, using the pre-edge speed value.
- set with speed<MIN_CRUISE SHALL be ignored.
REQ-010 CRUISE transitions:
- brake or cancel SHALL go to STANDBY.
- set SHALL reload cruise_speed<=speed and stay in CRUISE.
- accel SHALL go to ACCEL.
- coast SHALL go to COAST.
REQ-011 ACCEL and COAST transitions:
- brake or cancel SHALL go to STANDBY.
- Deassertion of the state's own input SHALL return to CRUISE on the next edge.
REQ-012 STANDBY transitions:
- set with speed>=MIN_CRUISE SHALL go to CRUISE and reload cruise_speed.
- resume SHALL go to CRUISE with cruise_speed unchanged.
- Both are ignored while brake or cancel is high.
REQ-013 Speed update, one per cycle, 1-cycle latency:
- brake high: speed-2, saturating at 0, in every state.
- Otherwise in IDLE and STANDBY: throttle gives +1, no throttle gives -1.
- Otherwise in CRUISE: throttle gives +1 (driver override); no throttle moves speed 1 toward cruise_speed, and holds it when equal.
- Otherwise in ACCEL: +1.
- Otherwise in COAST: -1.
REQ-014 In ACCEL, cruise_speed SHALL increment by 1 per cycle, saturating at MAX_SPEED.
REQ-015 In COAST, cruise_speed SHALL decrement by 1 per cycle, holding at MIN_CRUISE, never below it.
REQ-016 All arithmetic SHALL be 8-bit unsigned, saturating with no wrap:
- speed is clamped to [0, MAX_SPEED].
- 0-2 SHALL give 0 and 1-2 SHALL give 0.
- MAX_SPEED+1 SHALL give MAX_SPEED.
REQ-017 cruise_on SHALL be registered and SHALL reflect the state entered on the same edge.
REQ-018 Asserting accel and coast together SHALL select ACCEL.

Reset
REQ-019 When reset_n is low at a rising edge of clock, the block SHALL set state=IDLE, speed=0, cruise_speed=0 and cruise_on=0.
REQ-020 Reset SHALL take priority over all inputs in any state, including mid-ACCEL and mid-COAST.
REQ-021 The first post-reset update SHALL occur on the first edge with reset_n high.

Configuration
REQ-022 The block SHALL compile the resume feature in or out with the macro CRUISE_RESUME_EN.
REQ-023 With CRUISE_RESUME_EN defined, STANDBY and the resume input SHALL behave as in REQ-012, and cruise_speed SHALL be retained across brake and cancel.
REQ-024 With CRUISE_RESUME_EN undefined:
- STANDBY SHALL not exist.
- brake or cancel from CRUISE, ACCEL or COAST SHALL go to IDLE and clear cruise_speed to 0.
- resume SHALL be ignored.

Verification
REQ-025 Throttle held 50 cycles from reset, then set pulse -> speed=50, CRUISE, cruise_speed=50, cruise_on=1 one cycle after set.
REQ-026 Speed 30, set pulse -> state stays IDLE, cruise_on=0; speed=1 with brake -> speed=0, no underflow.
REQ-027 Cruising at 60, accel held 5 cycles then released -> cruise_speed=65, speed=65, back in CRUISE; coast held 30 cycles -> cruise_speed holds at 45.
REQ-028 Cruising at 60, brake 3 cycles, then resume -> speed 54 in STANDBY with cruise_speed 60; after resume, speed climbs 1/cycle to 60 and holds (CRUISE_RESUME_EN defined).
REQ-029 Same stimulus with CRUISE_RESUME_EN undefined -> state IDLE, cruise_speed=0, resume ignored.
REQ-030 reset_n low for one edge during ACCEL at cruise_speed 100 -> next cycle IDLE, speed=0, cruise_speed=0, cruise_on=0.
